// File: rtl/night_rider_monitor_pkg.sv
// Shared types for the night-rider sweep monitor: FSM state encoding and
// the LED-index width helper.
package night_rider_pkg;

    typedef enum logic [1:0] {
        HUNT    = 2'b00,
        ACQUIRE = 2'b01,
        LOCKED  = 2'b10
    } nr_state_e;

    function automatic int nr_width(input int n);
        return $clog2(n);
    endfunction

endpackage

// File: rtl/night_rider_monitor_if.sv
// LED sample bus into the monitor and its status outputs back out.
// master = scanner/observer side, slave = monitor side.
interface night_rider_monitor_if #(
    parameter int N     = 8,
    parameter int CNT_W = 16
);
    import night_rider_pkg::*;
    localparam int W = nr_width(N);

    logic [N-1:0]     led_in;
    logic             led_valid;
    logic [W-1:0]     pos;
    logic             dir;
    logic             locked;
    logic             err_pulse;
    logic [CNT_W-1:0] err_count;
    logic [CNT_W-1:0] sweep_count;

    modport master (
        output led_in, led_valid,
        input  pos, dir, locked, err_pulse, err_count, sweep_count
    );

    modport slave (
        input  led_in, led_valid,
        output pos, dir, locked, err_pulse, err_count, sweep_count
    );

endinterface

// File: rtl/night_rider_onehot_dec.sv
// One-hot decoder: reports whether exactly one bit is set and its index.
// The index is only meaningful when is_onehot_o is high.
module night_rider_onehot_dec
    import night_rider_pkg::*;
#(
    parameter int N = 8,
    localparam int W = nr_width(N)
) (
    input  logic [N-1:0] vec_i,
    output logic [W-1:0] idx_o,
    output logic         is_onehot_o
);

    always_comb begin
        idx_o = '0;
        for (int i = 0; i < N; i++) begin
            if (vec_i[i]) idx_o = W'(i);
        end
    end

    // Clearing the lowest set bit leaves zero only for a single-bit word.
    assign is_onehot_o = (vec_i != '0) && ((vec_i & (vec_i - N'(1))) == '0);

endmodule

// File: rtl/night_rider_monitor.sv
// Locks onto a bouncing one-hot LED sweep, tracks position/direction,
// flags sequence breaks and counts end-to-end sweeps.
module night_rider_monitor
    import night_rider_pkg::*;
#(
    parameter int N     = 8,
    parameter int CNT_W = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    night_rider_monitor_if.slave    bus
);

    localparam int W = nr_width(N);
    localparam logic [W-1:0] LAST  = W'(N - 1);
    localparam logic [W:0]   ONE_X = (W + 1)'(1);

    nr_state_e        state_q, state_d;
    logic [W-1:0]     pos_q, pos_d;
    logic             dir_q, dir_d;
    logic             locked_q, locked_d;
    logic             errp_q, errp_d;
    logic [CNT_W-1:0] errc_q, errc_d;
    logic [CNT_W-1:0] swc_q, swc_d;

    logic [W-1:0] k;
    logic         onehot;
    logic [W-1:0] e;
    logic         up_adj, dn_adj;

    night_rider_onehot_dec #(.N(N)) u_dec (
        .vec_i       (bus.led_in),
        .idx_o       (k),
        .is_onehot_o (onehot)
    );

    // Adjacency is checked one bit wider so pos 0 and N-1 never alias via wrap.
    assign up_adj = ({1'b0, k} == {1'b0, pos_q} + ONE_X);
    assign dn_adj = ({1'b0, k} + ONE_X == {1'b0, pos_q});
    assign e      = dir_q ? pos_q + W'(1) : pos_q - W'(1);

    always_comb begin
        state_d = state_q;
        pos_d   = pos_q;
        dir_d   = dir_q;
        errp_d  = 1'b0;
        errc_d  = errc_q;
        swc_d   = swc_q;
        if (bus.led_valid) begin
            unique case (state_q)
                HUNT: begin
                    if (onehot) begin
                        pos_d = k;
                        if (k == '0) begin
                            state_d = LOCKED;
                            dir_d   = 1'b1;
                        end else if (k == LAST) begin
                            state_d = LOCKED;
                            dir_d   = 1'b0;
                        end else begin
                            state_d = ACQUIRE;
                        end
                    end
                end
                ACQUIRE: begin
                    if (!onehot) begin
                        state_d = HUNT;
                    end else begin
                        pos_d = k;
                        if (up_adj || dn_adj) begin
                            state_d = LOCKED;
                            dir_d   = up_adj;
                            if (k == '0)  dir_d = 1'b1;
                            if (k == LAST) dir_d = 1'b0;
                        end
                    end
                end
                LOCKED: begin
                    if (onehot && k == e) begin
                        pos_d = e;
                        if (e == LAST || e == '0) begin
                            dir_d = (e == '0);
                            if (swc_q != '1) swc_d = swc_q + CNT_W'(1);
                        end
                    end else begin
                        state_d = HUNT;
                        errp_d  = 1'b1;
                        if (errc_q != '1) errc_d = errc_q + CNT_W'(1);
                    end
                end
                default: state_d = HUNT;
            endcase
        end else if (state_q != HUNT && state_q != ACQUIRE && state_q != LOCKED) begin
            state_d = HUNT;
        end
        locked_d = (state_d == LOCKED);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= HUNT;
            pos_q    <= '0;
            dir_q    <= 1'b1;
            locked_q <= 1'b0;
            errp_q   <= 1'b0;
            errc_q   <= '0;
            swc_q    <= '0;
        end else begin
            state_q  <= state_d;
            pos_q    <= pos_d;
            dir_q    <= dir_d;
            locked_q <= locked_d;
            errp_q   <= errp_d;
            errc_q   <= errc_d;
            swc_q    <= swc_d;
        end
    end

    assign bus.pos         = pos_q;
    assign bus.dir         = dir_q;
    assign bus.locked      = locked_q;
    assign bus.err_pulse   = errp_q;
    assign bus.err_count   = errc_q;
    assign bus.sweep_count = swc_q;

endmodule

// File: doc/night_rider_monitor.md
# night_rider_monitor

Receive-side checker for the night-rider LED scanner. It samples a one-hot LED bus, locks onto the bouncing sweep pattern and reports the current position and direction. It flags every step that breaks the sequence and counts completed end-to-end sweeps. It sits on the consuming side of the scanner's LED output, for self-test and board bring-up.

## Interface
- `N`, 8: LED bus width; legal range N >= 3.
- `CNT_W`, 16: width of the error and sweep counters.
- `clk` in 1: single clock; all logic on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `led_in` in N: observed LED pattern; bit i = LED i.
- `led_valid` in 1: sample strobe; `led_in` is consumed only when high. Tie high when the scanner steps every clock.
- `pos` out W: index of the last accepted LED, W = $clog2(N).
- `dir` out 1: direction of the next expected step; 1 = up (index +1), 0 = down.
- `locked` out 1: high while in LOCKED.
- `err_pulse` out 1: one-cycle pulse per sequence error.
- `err_count` out CNT_W: saturating count of errors.
- `sweep_count` out CNT_W: saturating count of end arrivals while locked.

## Operation
- Decode: a sample is one-hot when exactly one bit is set, giving index k. Zero bits or multiple bits means not one-hot.
- **HUNT** (reset state), on each valid sample:
  - k = 0: go to LOCKED, pos=0, dir=1.
  - k = N-1: go to LOCKED, pos=N-1, dir=0.
  - 0 < k < N-1: go to ACQUIRE, pos=k.
  - Not one-hot: stay in HUNT. No error.
- **ACQUIRE**, on each valid sample:
  - k = pos+1: go to LOCKED, dir=1.
  - k = pos-1: go to LOCKED, dir=0.
  - On either lock, pos=k. If k is 0 the direction is forced to dir=1; if k is N-1 it is forced to dir=0.
  - Other one-hot k: stay in ACQUIRE, pos=k.
  - Not one-hot: go to HUNT.
  - No errors are flagged in ACQUIRE. No sweep is counted on a lock.
- **LOCKED**:
  - Expected index e = pos+1 if dir=1, else pos-1.
  - Valid sample equal to one-hot(e): accept it and set pos=e.
    - e = N-1: set dir=0 and increment sweep_count.
    - e = 0: set dir=1 and increment sweep_count.
  - Any other valid sample (wrong index, repeated index, zero, multi-hot): err_pulse=1, increment err_count, go to HUNT. pos and dir hold.
- Counters saturate at 2^CNT_W-1 and never wrap.
- `led_valid` low: no state, output or counter change; err_pulse=0.
- Arithmetic: e is computed in W bits. Out-of-range e cannot occur because dir is forced at both ends.

## Timing
- All outputs are registered. The response to a sample on edge t is visible after edge t, i.e. one-cycle latency.
- err_pulse is high for exactly the cycle after the offending sample. Back-to-back errors are impossible, since the first error drops to HUNT.
- Reset values: pos=0, dir=1, locked=0, err_pulse=0, err_count=0, sweep_count=0, state=HUNT.
- rst high at an edge overrides any sample on the same edge, including a sample in mid-lock. Outputs read reset values from the next cycle.
- A scanner stepping every clock with led_valid tied high is tracked with zero errors indefinitely.

## Structure
- Shared package `night_rider_pkg` holds:
  - the state typedef/constants HUNT=2'b00, ACQUIRE=2'b01, LOCKED=2'b10;
  - a width helper returning $clog2(N).
  - Unused state encoding goes to HUNT.
- One combinational sub-module, `night_rider_onehot_dec`. Parameter N; outputs index (W bits) and `is_onehot`. The monitor holds the FSM, pos/dir registers and counters.

## Test plan
All cases use N=8, CNT_W=16 unless stated.
1. After reset, feed 0x01,0x02,…,0x80,0x40,…,0x01 (15 samples) with valid every cycle. Expect locked=1 from the cycle after 0x01, err_count=0, sweep_count=2, final pos=0, dir=1.
2. Start mid-sweep with 0x08 then 0x10. Expect locked=1, pos=4, dir=1. From reset, 0x08 then 0x04 gives pos=2, dir=0. From reset, 0x40 then 0x80 gives pos=7, dir=0.
3. While locked at pos=3, dir=1, inject 0x20. Expect err_pulse high for one cycle, err_count=1, locked=0. Then 0x20,0x40 relocks with pos=6, dir=1.
4. While locked, inject 0x00, then after relock inject 0x18; each gives one err_pulse, err_count=2. The same values in HUNT give no error.
5. At pos=7, dir=0, inject 0x80 again: error. Hold led_valid low for 5 cycles mid-lock: all outputs unchanged. With CNT_W=4, 20 forced errors leave err_count at 15.
6. Assert rst for one cycle while locked with err_count=3 and sweep_count=5, with a valid sample present on the same edge. Next cycle every output is at its reset value.
